// File: rtl/fifo_datapath.sv
// FIFO storage and pointer datapath, the responder to the FIFO controller FSM.
// Optional sticky error flags are built when FIFO_DATAPATH_ERR_EN is defined.
module fifo_datapath #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        control_signals,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [1:0]        status_signals,
    output logic [ADDR_W:0]   count,
    output logic              overflow_err,
    output logic              underflow_err,
    output logic              cmd_err
);

    localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;

    logic clr;
    logic wr;
    logic rd;
    logic bad;
    logic full;
    logic empty;
    logic do_wr;
    logic do_rd;

    // Command decode; a write into a full FIFO is allowed only alongside a read.
    always_comb begin
        clr   = control_signals[2];
        wr    = control_signals[4] & control_signals[0];
        rd    = control_signals[3] & control_signals[1];
        bad   = (control_signals[4] ^ control_signals[0]) |
                (control_signals[3] ^ control_signals[1]);
        full  = (count == FULL_CNT);
        empty = (count == '0);
        do_rd = rd & ~empty & ~clr;
        do_wr = wr & ~clr & (~full | do_rd);
        status_signals = {empty, full};
    end

    // Storage array write port, deliberately not reset.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers, occupancy and registered read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            dout   <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_DATAPATH_ERR_EN
    // Sticky error flags, cleared only by reset or a clear command.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            cmd_err       <= 1'b0;
        end else if (clr) begin
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            cmd_err       <= 1'b0;
        end else begin
            if (wr && full && !do_rd) begin
                overflow_err <= 1'b1;
            end
            if (rd && empty) begin
                underflow_err <= 1'b1;
            end
            if (bad) begin
                cmd_err <= 1'b1;
            end
        end
    end
`else
    assign overflow_err  = 1'b0;
    assign underflow_err = 1'b0;
    assign cmd_err       = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_datapath.sv
// Directed self-checking bench for fifo_datapath.
// Error-flag expectations follow FIFO_DATAPATH_ERR_EN.
module tb_fifo_datapath;

    localparam logic [4:0] IDLE = 5'b00000;
    localparam logic [4:0] CLR  = 5'b00100;
    localparam logic [4:0] WR   = 5'b10001;
    localparam logic [4:0] RD   = 5'b01010;
    localparam logic [4:0] WRRD = 5'b11011;
    localparam logic [4:0] BADW = 5'b10000;

`ifdef FIFO_DATAPATH_ERR_EN
    localparam logic ERR = 1'b1;
`else
    localparam logic ERR = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [4:0] control_signals;
    logic [7:0] din;
    logic [7:0] dout;
    logic [1:0] status_signals;
    logic [4:0] count;
    logic       overflow_err;
    logic       underflow_err;
    logic       cmd_err;

    int n_chk;
    int n_pass;

    fifo_datapath dut (
        .clk             (clk),
        .rst             (rst),
        .control_signals (control_signals),
        .din             (din),
        .dout            (dout),
        .status_signals  (status_signals),
        .count           (count),
        .overflow_err    (overflow_err),
        .underflow_err   (underflow_err),
        .cmd_err         (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic [4:0] c, input logic [7:0] d);
        control_signals = c;
        din = d;
        @(posedge clk);
        #1;
        control_signals = IDLE;
    endtask

    initial begin
        n_chk = 0;
        n_pass = 0;
        rst = 1'b1;
        control_signals = IDLE;
        din = 8'h00;
        #3;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_status", 32'(status_signals), 32'b10);
        chk("rst_dout", 32'(dout), 32'h0);
        chk("rst_errs", 32'({overflow_err, underflow_err, cmd_err}), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // 1: fill to 6, read one (dout=A0, count=5), then async reset
        for (int i = 0; i < 6; i++) step(WR, 8'hA0 + 8'(i));
        step(RD, 8'h00);
        chk("t1_dout_pre", 32'(dout), 32'hA0);
        chk("t1_count_pre", 32'(count), 32'd5);
        #2;
        rst = 1'b1;
        #1;
        chk("t1_count", 32'(count), 32'd0);
        chk("t1_status", 32'(status_signals), 32'b10);
        chk("t1_dout", 32'(dout), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // 2: clear then 16 writes
        step(CLR, 8'h00);
        for (int i = 1; i <= 16; i++) step(WR, 8'(i));
        chk("t2_count", 32'(count), 32'd16);
        chk("t2_status", 32'(status_signals), 32'b01);

        // 3: write while full
        step(WR, 8'hFF);
        chk("t3_count", 32'(count), 32'd16);
        chk("t3_ovf", 32'(overflow_err), 32'(ERR));

        // 4: drain 16 words in order
        for (int i = 1; i <= 16; i++) begin
            step(RD, 8'h00);
            chk($sformatf("t4_dout%0d", i), 32'(dout), 32'(i));
        end
        chk("t4_status", 32'(status_signals), 32'b10);
        chk("t4_count", 32'(count), 32'd0);

        // 5a: read while empty, also with a concurrent write
        step(RD, 8'h00);
        chk("t5_dout_hold", 32'(dout), 32'h10);
        chk("t5_unf", 32'(underflow_err), 32'(ERR));
        chk("t5_count_e", 32'(count), 32'd0);
        step(WRRD, 8'h77);
        chk("t5_wrrd_e_dout", 32'(dout), 32'h10);
        chk("t5_wrrd_e_count", 32'(count), 32'd1);

        // 5b: write+read at full
        step(CLR, 8'h00);
        chk("t5_clr_errs", 32'({overflow_err, underflow_err}), 32'd0);
        for (int i = 0; i < 16; i++) step(WR, 8'h21 + 8'(i));
        step(WRRD, 8'h55);
        chk("t5_wrrd_count", 32'(count), 32'd16);
        chk("t5_wrrd_dout", 32'(dout), 32'h21);
        chk("t5_wrrd_ovf", 32'(overflow_err), 32'd0);
        for (int i = 1; i < 16; i++) begin
            step(RD, 8'h00);
            chk($sformatf("t5_rd%0d", i), 32'(dout), 32'h21 + 32'(i));
        end
        step(RD, 8'h00);
        chk("t5_last", 32'(dout), 32'h55);
        chk("t5_empty", 32'(status_signals), 32'b10);

        // 6: malformed write, then clear
        step(BADW, 8'hEE);
        chk("t6_count", 32'(count), 32'd0);
        chk("t6_cmd", 32'(cmd_err), 32'(ERR));
        step(WR, 8'h3C);
        step(RD, 8'h00);
        chk("t6_no_write", 32'(dout), 32'h3C);
        step(CLR, 8'h00);
        chk("t6_cmd_clr", 32'(cmd_err), 32'd0);
        chk("t6_status", 32'(status_signals), 32'b10);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
